l1_icache: RTL

//  2-way set-associative, read-only L1 instruction cache directly downstream of the pipeline fetch port.

---
 rtl/icache_types.sv | 23 ++
 rtl/icache_way.sv | 53 +++++
 rtl/l1_icache.sv | 132 +++++++++++++
 3 files changed

// File: rtl/icache_types.sv
// ============================================================================
// Module   : icache_types
// Brief    : Shared types and sizes for the L1 instruction cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

package icache_types;

    localparam int S_LINE   = 256;
    localparam int S_TAG    = 32 - 5 - 3;
    localparam int NUM_SETS = 8;

    typedef logic [S_LINE-1:0] line_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_way.sv
// ============================================================================
// Module   : icache_way
// Brief    : One cache way: valid/tag/data arrays, combinational read, load write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_way
    import icache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = S_TAG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [S_INDEX-1:0] index,
    input  logic [TAG_W-1:0]   wtag,
    input  line_t              wline,
    output logic               valid,
    output logic [TAG_W-1:0]   tag,
    output line_t              line
);

    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    line_t            r_data [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (load) begin
            r_valid[index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (load) begin
            r_tag[index]  <= wtag;
            r_data[index] <= wline;
        end
    end

    assign valid = r_valid[index];
    assign tag   = r_tag[index];
    assign line  = r_data[index];

endmodule

`default_nettype wire

// File: rtl/l1_icache.sv
// ============================================================================
// Module   : l1_icache
// Brief    : 2-way set-associative read-only L1 I-cache, same-cycle hits, line fills.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l1_icache
    import icache_types::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_read,
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_rdata,
    output logic        icache_resp,
    output logic        pmem_read,
    output logic [31:0] pmem_address,
    input  line_t       pmem_rdata,
    input  logic        pmem_resp
);

    localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;
    localparam int SETS   = 1 << S_INDEX;
    localparam int WSEL_W = S_OFFSET - 2;

    icache_state_t     r_state;
    logic [31:0]       r_fill_addr;
    logic [SETS-1:0]   r_lru;

    logic [S_INDEX-1:0] w_req_index;
    logic [TAG_W-1:0]   w_req_tag;
    logic [WSEL_W-1:0]  w_word;
    logic [S_INDEX-1:0] w_fill_index;
    logic [TAG_W-1:0]   w_fill_tag;
    logic [S_INDEX-1:0] w_index;

    logic [1:0]         w_valid;
    logic [TAG_W-1:0]   w_tag  [2];
    line_t              w_line [2];
    logic [1:0]         w_load;
    logic [1:0]         w_hit_way;

    logic               w_lookup;
    logic               w_hit;
    logic               w_miss;
    logic               w_hit_sel;
    logic               w_victim;
    logic               w_fill_done;
    line_t              w_sel_line;
    logic               w_unused;

    assign w_req_index  = icache_addr[S_OFFSET +: S_INDEX];
    assign w_req_tag    = icache_addr[31 -: TAG_W];
    assign w_word       = icache_addr[S_OFFSET-1:2];
    assign w_fill_index = r_fill_addr[S_OFFSET +: S_INDEX];
    assign w_fill_tag   = r_fill_addr[31 -: TAG_W];
    assign w_unused     = &{1'b0, icache_addr[1:0]};

    // During a fill the arrays look at the latched set so victim choice ignores the live PC.
    assign w_index = (r_state == FILL) ? w_fill_index : w_req_index;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_way
            icache_way #(
                .S_INDEX (S_INDEX),
                .TAG_W   (TAG_W)
            ) u_way (
                .clk   (clk),
                .rst   (rst),
                .load  (w_load[i]),
                .index (w_index),
                .wtag  (w_fill_tag),
                .wline (pmem_rdata),
                .valid (w_valid[i]),
                .tag   (w_tag[i]),
                .line  (w_line[i])
            );

            assign w_hit_way[i] = w_valid[i] && (w_tag[i] == w_req_tag);
            assign w_load[i]    = w_fill_done && (w_victim == 1'(i));
        end
    endgenerate

    assign w_lookup    = (r_state == IDLE) && icache_read;
    assign w_hit       = w_lookup && (|w_hit_way);
    assign w_miss      = w_lookup && !(|w_hit_way);
    assign w_hit_sel   = w_hit_way[1];
    assign w_sel_line  = w_line[w_hit_sel];
    assign w_fill_done = (r_state == FILL) && pmem_resp;

    assign w_victim = !w_valid[0] ? 1'b0 :
                      !w_valid[1] ? 1'b1 : r_lru[w_fill_index];

    assign icache_resp  = w_hit;
    assign icache_rdata = w_hit ? w_sel_line[w_word*32 +: 32] : 32'h0;
    assign pmem_read    = (r_state == FILL);
    assign pmem_address = pmem_read ? r_fill_addr : 32'h0;

    // lru[set] names the next victim, so it always points away from the way just used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lru       <= '0;
            r_fill_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_lru[w_req_index] <= ~w_hit_sel;
                    end else if (w_miss) begin
                        r_fill_addr <= {icache_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_lru[w_fill_index] <= ~w_victim;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
